// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU command sequencer: operand/result widths,
// ALU opcode constants, FSM state type, command word layout and a helper
// that recognises divide/modulo-by-zero commands.
// -----------------------------------------------------------------------------
package alu_seq_pkg;

   localparam int OPND_W = 4;                       // ALU operand width
   localparam int RES_W  = 5;                       // ALU result width
   localparam int SEL_W  = 3;                       // opcode width
   localparam int CMD_W  = 3 * OPND_W + SEL_W;      // buffered command word

   // ALU opcodes
   localparam logic [SEL_W-1:0] SEL_MAX = 3'b000;   // max(a, b, c)
   localparam logic [SEL_W-1:0] SEL_ADD = 3'b001;
   localparam logic [SEL_W-1:0] SEL_SUB = 3'b010;
   localparam logic [SEL_W-1:0] SEL_DIV = 3'b011;
   localparam logic [SEL_W-1:0] SEL_MOD = 3'b100;
   localparam logic [SEL_W-1:0] SEL_AND = 3'b101;
   localparam logic [SEL_W-1:0] SEL_XOR = 3'b110;
   localparam logic [SEL_W-1:0] SEL_GT  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } seq_state_t;

   typedef struct packed {
      logic [OPND_W-1:0] a;
      logic [OPND_W-1:0] b;
      logic [OPND_W-1:0] c;
      logic [SEL_W-1:0]  sel;
   } alu_cmd_t;

   // True for a divide or modulo whose divisor is zero.
   function automatic logic is_div_by_zero(input alu_cmd_t cmd);
      if (((cmd.sel == SEL_DIV) || (cmd.sel == SEL_MOD)) && (cmd.b == 4'b0000)) begin
         return 1'b1;
      end else begin
         return 1'b0;
      end
   endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// -----------------------------------------------------------------------------
// alu_cmd_fifo
// Synchronous first-word-fall-through command buffer.
// Ports:
//   clk, rst              clock, synchronous active-high reset (empties buffer)
//   push, push_data       write request and word (ignored when full)
//   pop, pop_data         read request (ignored when empty) and head word
//   full, empty           occupancy flags
// -----------------------------------------------------------------------------
module alu_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign do_push_s = push && !full;
   assign do_pop_s  = pop && !empty;
   assign full      = (count_r == (AW+1)'(DEPTH));
   assign empty     = (count_r == {(AW+1){1'b0}});
   assign pop_data  = mem_r[rd_ptr_r];

   // Storage array: written on accepted pushes only, no reset needed.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;   // none, or push+pop together
         endcase
      end
   end

endmodule

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
// Buffers ALU commands, issues them one at a time to an externally attached
// registered ALU, waits out its latency, and returns each result over a
// valid/ready response channel.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_a, cmd_b, cmd_c, cmd_sel     command operands and opcode
//   alu_a, alu_b, alu_c, alu_sel     registered drive to the ALU
//   alu_result                       ALU registered result
//   rsp_valid/rsp_ready              response handshake
//   rsp_data, rsp_err                captured result and error flag
//   busy                             FSM not idle or commands buffered
// Build option: define ALU_SEQ_DIV0_CHECK_EN to answer divide/modulo by zero
// locally with rsp_err=1 instead of sending it to the ALU.
// -----------------------------------------------------------------------------
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int ALU_LAT    = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_a,
   input  logic [3:0] cmd_b,
   input  logic [3:0] cmd_c,
   input  logic [2:0] cmd_sel,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [3:0] alu_c,
   output logic [2:0] alu_sel,
   input  logic [4:0] alu_result,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [4:0] rsp_data,
   output logic       rsp_err,
   output logic       busy
);

   localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT + 1) : 1;

   seq_state_t       state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   alu_cmd_t         alu_cmd_r, alu_cmd_s;
   alu_cmd_t         head_s;
   alu_cmd_t         push_cmd_s;
   logic             rsp_valid_r, rsp_valid_s;
   logic [RES_W-1:0] rsp_data_r, rsp_data_s;
   logic             rsp_err_r, rsp_err_s;
   logic             full_s, empty_s;
   logic             push_s, pop_s, issue_s;

   assign cmd_ready  = !full_s && !rst;
   assign push_s     = cmd_valid && cmd_ready;
   assign push_cmd_s = '{a: cmd_a, b: cmd_b, c: cmd_c, sel: cmd_sel};

   alu_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_s),
      .push_data (push_cmd_s),
      .pop       (pop_s),
      .pop_data  (head_s),
      .full      (full_s),
      .empty     (empty_s)
   );

   // Next-state and output logic; issue of the FIFO head is shared by IDLE
   // and by a RESP handshake so back-to-back commands lose no cycle.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      alu_cmd_s   = alu_cmd_r;
      rsp_valid_s = rsp_valid_r;
      rsp_data_s  = rsp_data_r;
      rsp_err_s   = rsp_err_r;
      issue_s     = 1'b0;
      pop_s       = 1'b0;

      case (state_r)
         ST_IDLE: begin
            issue_s = !empty_s;
         end
         ST_WAIT: begin
            // Counter starts at ALU_LAT, so WAIT spans ALU_LAT+1 edges.
            if (cnt_r == {CNT_W{1'b0}}) begin
               state_s     = ST_RESP;
               rsp_valid_s = 1'b1;
               rsp_data_s  = alu_result;
               rsp_err_s   = 1'b0;
            end else begin
               cnt_s = cnt_r - CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_s = 1'b0;
               if (!empty_s) begin
                  issue_s = 1'b1;
               end else begin
                  state_s = ST_IDLE;
               end
            end else begin
               rsp_valid_s = 1'b1;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase

      if (issue_s) begin
         pop_s       = 1'b1;
         alu_cmd_s   = head_s;
         cnt_s       = CNT_W'(ALU_LAT);
         state_s     = ST_WAIT;
         rsp_valid_s = 1'b0;
`ifdef ALU_SEQ_DIV0_CHECK_EN
         // Answer a zero divisor locally; the ALU keeps its previous operands.
         if (is_div_by_zero(head_s)) begin
            alu_cmd_s   = alu_cmd_r;
            cnt_s       = {CNT_W{1'b0}};
            state_s     = ST_RESP;
            rsp_valid_s = 1'b1;
            rsp_data_s  = {RES_W{1'b0}};
            rsp_err_s   = 1'b1;
         end else begin
            rsp_err_s   = 1'b0;
         end
`endif
      end else begin
         pop_s = 1'b0;
      end
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         cnt_r       <= {CNT_W{1'b0}};
         alu_cmd_r   <= '{a: 4'h0, b: 4'h0, c: 4'h0, sel: 3'b000};
         rsp_valid_r <= 1'b0;
         rsp_data_r  <= {RES_W{1'b0}};
         rsp_err_r   <= 1'b0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         alu_cmd_r   <= alu_cmd_s;
         rsp_valid_r <= rsp_valid_s;
         rsp_data_r  <= rsp_data_s;
         rsp_err_r   <= rsp_err_s;
      end
   end

   assign alu_a     = alu_cmd_r.a;
   assign alu_b     = alu_cmd_r.b;
   assign alu_c     = alu_cmd_r.c;
   assign alu_sel   = alu_cmd_r.sel;
   assign rsp_valid = rsp_valid_r;
   assign rsp_data  = rsp_data_r;
   assign rsp_err   = rsp_err_r;
   assign busy      = (state_r != ST_IDLE) || !empty_s;

endmodule
